// File: rtl/msg_pkg.sv
// Shared types and sizing for the ping-pong navigation message scheduler.
package msg_pkg;

  localparam int MESSAGE_LEN_DEF = 120;
  localparam int WR_WIDTH_DEF    = 8;

  // Number of host words needed to cover a whole message.
  function automatic int msg_words(input int len, input int width);
    return (len + width - 1) / width;
  endfunction

  typedef logic bank_sel_t;

  typedef enum logic {
    FILL    = 1'b0,
    PENDING = 1'b1
  } host_state_e;

endpackage

// File: rtl/msg_bank_sched_if.sv
// Host-side write/commit port of the message scheduler.
interface msg_bank_sched_if
  import msg_pkg::*;
#(
  parameter int AW = $clog2(msg_words(MESSAGE_LEN_DEF, WR_WIDTH_DEF)),
  parameter int DW = WR_WIDTH_DEF
);
  // Handshake: a write (or commit) transfers on a clock edge where its valid and
  // ready are both high; ready depends only on scheduler state, never on valid.
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          commit_valid;
  logic          commit_ready;

  modport master (
    output wr_valid, wr_addr, wr_data, commit_valid,
    input  wr_ready, commit_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, commit_valid,
    output wr_ready, commit_ready
  );
endinterface

// File: rtl/msg_bank.sv
// One message bank: word-wide write port, combinational single-bit read port.
module msg_bank
  import msg_pkg::*;
#(
  parameter  int MESSAGE_LEN = MESSAGE_LEN_DEF,
  parameter  int WR_WIDTH    = WR_WIDTH_DEF,
  localparam int MSG_WORDS   = msg_words(MESSAGE_LEN, WR_WIDTH),
  localparam int AW          = $clog2(MSG_WORDS),
  localparam int RW          = $clog2(MESSAGE_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [AW-1:0]       i_addr,
  input  logic [WR_WIDTH-1:0] i_data,
  input  logic [RW-1:0]       i_rd_addr,
  output logic                o_rd_bit
);

  logic [MESSAGE_LEN-1:0] w_bits;

  // Each bit only exists below MESSAGE_LEN, so padding bits of the last word
  // and out-of-range word addresses never match any storage.
  for (genvar b = 0; b < MESSAGE_LEN; b++) begin : g_bit
    logic r_b;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_b <= 1'b0;
      end else if (i_we && (i_addr == AW'(b / WR_WIDTH))) begin
        r_b <= i_data[b % WR_WIDTH];
      end
    end
    assign w_bits[b] = r_b;
  end

  assign o_rd_bit = (32'(i_rd_addr) < MESSAGE_LEN) ? w_bits[i_rd_addr] : 1'b0;

endmodule

// File: rtl/msg_bank_sched.sv
// Ping-pong navigation message scheduler: host fills the back bank, banks swap
// only on a frame boundary, and the front bank serves one bit per msg_addr.
module msg_bank_sched
  import msg_pkg::*;
#(
  parameter  int MESSAGE_LEN = MESSAGE_LEN_DEF,
  parameter  int WR_WIDTH    = WR_WIDTH_DEF,
  localparam int MSG_WORDS   = msg_words(MESSAGE_LEN, WR_WIDTH),
  localparam int RW          = $clog2(MESSAGE_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  msg_bank_sched_if.slave     host,
  input  logic                frame_start,
  input  logic [RW-1:0]       msg_addr,
  output logic                msg_bit,
  output logic                active_bank,
  output logic                pending,
  output logic                swap_pulse,
  output logic [15:0]         repeat_cnt,
  output logic                wr_err,
  output host_state_e         o_dbg_state
);

  host_state_e r_state;
  host_state_e w_state_nxt;
  bank_sel_t   r_active;
  bank_sel_t   w_front;

  logic        w_wr_fire;
  logic        w_commit_fire;
  logic        w_swap;
  logic        w_we0;
  logic        w_we1;
  logic        w_bit0;
  logic        w_bit1;
  logic        w_err_addr;
  logic        r_msg_bit;
  logic        r_swap_pulse;
  logic        r_wr_err;
  logic [15:0] r_repeat;

  assign host.wr_ready     = (r_state == FILL);
  assign host.commit_ready = (r_state == FILL);
  assign w_wr_fire         = host.wr_valid && host.wr_ready;
  assign w_commit_fire     = host.commit_valid && host.commit_ready;
  assign w_err_addr        = (32'(host.wr_addr) >= MSG_WORDS);

  // A swap needs a commit that was already pending when the boundary arrives.
  assign w_swap  = frame_start && (r_state == PENDING);
  assign w_front = w_swap ? ~r_active : r_active;

  // Writes always land in the bank that is not being served.
  assign w_we0 = w_wr_fire && (r_active == 1'b1);
  assign w_we1 = w_wr_fire && (r_active == 1'b0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_commit_fire) w_state_nxt = PENDING;
      PENDING: if (frame_start)   w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active     <= 1'b0;
      r_msg_bit    <= 1'b0;
      r_swap_pulse <= 1'b0;
      r_repeat     <= '0;
      r_wr_err     <= 1'b0;
    end else begin
      r_active     <= w_front;
      r_msg_bit    <= w_front ? w_bit1 : w_bit0;
      r_swap_pulse <= w_swap;
      if (frame_start && (r_state == FILL) && (r_repeat != 16'hFFFF)) begin
        r_repeat <= r_repeat + 16'd1;
      end
      if (w_wr_fire && w_err_addr) begin
        r_wr_err <= 1'b1;
      end
    end
  end

  msg_bank #(.MESSAGE_LEN(MESSAGE_LEN), .WR_WIDTH(WR_WIDTH)) u_bank0 (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we0),
    .i_addr    (host.wr_addr),
    .i_data    (host.wr_data),
    .i_rd_addr (msg_addr),
    .o_rd_bit  (w_bit0)
  );

  msg_bank #(.MESSAGE_LEN(MESSAGE_LEN), .WR_WIDTH(WR_WIDTH)) u_bank1 (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we1),
    .i_addr    (host.wr_addr),
    .i_data    (host.wr_data),
    .i_rd_addr (msg_addr),
    .o_rd_bit  (w_bit1)
  );

  assign msg_bit     = r_msg_bit;
  assign active_bank = r_active;
  assign pending     = (r_state == PENDING);
  assign swap_pulse  = r_swap_pulse;
  assign repeat_cnt  = r_repeat;
  assign wr_err      = r_wr_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_msg_bank_sched.sv
// Self-checking bench for msg_bank_sched: reference model + expected queue,
// a read-vector table, and hand-written boundary sequences.
module tb_msg_bank_sched;
  import msg_pkg::*;

  logic              clk;
  logic              rst;
  logic              frame_start;
  logic [6:0]        msg_addr;
  logic              msg_bit;
  logic              active_bank;
  logic              pending;
  logic              swap_pulse;
  logic [15:0]       repeat_cnt;
  logic              wr_err;
  host_state_e       dbg_state;

  msg_bank_sched_if host_if ();

  msg_bank_sched dut (
    .clk         (clk),
    .rst         (rst),
    .host        (host_if.slave),
    .frame_start (frame_start),
    .msg_addr    (msg_addr),
    .msg_bit     (msg_bit),
    .active_bank (active_bank),
    .pending     (pending),
    .swap_pulse  (swap_pulse),
    .repeat_cnt  (repeat_cnt),
    .wr_err      (wr_err),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [20:0] exp_q[$];

  logic [127:0] m_bank [2];
  logic         m_active;
  logic         m_pending;
  logic         m_swap;
  logic         m_bit;
  logic         m_err;
  logic [15:0]  m_repeat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply the current inputs for one clock edge, predict, then compare.
  task automatic cycle();
    logic [20:0] e;
    logic        nf;
    int          back;
    int          a;
    if (!rst) begin
      check("wr_ready", 32'(host_if.wr_ready), 32'(!m_pending));
      check("commit_ready", 32'(host_if.commit_ready), 32'(!m_pending));
      check("state", 32'(dbg_state), 32'(m_pending));
    end
    if (rst) begin
      m_bank[0] = '0; m_bank[1] = '0;
      m_active = 0; m_pending = 0; m_swap = 0; m_bit = 0; m_err = 0; m_repeat = '0;
    end else begin
      m_swap = frame_start && m_pending;
      nf     = m_swap ? ~m_active : m_active;
      m_bit  = (msg_addr < 7'd120) ? m_bank[nf ? 1 : 0][msg_addr] : 1'b0;
      back   = m_active ? 0 : 1;
      if (host_if.wr_valid && !m_pending) begin
        if (host_if.wr_addr < 4'd15) begin
          for (int k = 0; k < 8; k++) begin
            a = int'(host_if.wr_addr) * 8 + k;
            if (a < 120) m_bank[back][a] = host_if.wr_data[k];
          end
        end else begin
          m_err = 1'b1;
        end
      end
      if (frame_start && !m_pending && m_repeat != 16'hFFFF) m_repeat = m_repeat + 16'd1;
      m_pending = m_pending ? !frame_start : host_if.commit_valid;
      m_active  = nf;
    end
    exp_q.push_back({m_bit, m_swap, m_active, m_pending, m_err, m_repeat});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("msg_bit", 32'(msg_bit), 32'(e[20]));
    check("swap_pulse", 32'(swap_pulse), 32'(e[19]));
    check("active_bank", 32'(active_bank), 32'(e[18]));
    check("pending", 32'(pending), 32'(e[17]));
    check("wr_err", 32'(wr_err), 32'(e[16]));
    check("repeat_cnt", 32'(repeat_cnt), 32'(e[15:0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic wr(input int a, input logic [7:0] d);
    host_if.wr_valid = 1'b1;
    host_if.wr_addr  = 4'(a);
    host_if.wr_data  = d;
    cycle();
    host_if.wr_valid = 1'b0;
  endtask

  task automatic commit();
    host_if.commit_valid = 1'b1;
    cycle();
    host_if.commit_valid = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    msg_addr    = 7'd0;
    cycle();
    frame_start = 1'b0;
  endtask

  task automatic rd(input int a);
    msg_addr = 7'(a);
    cycle();
  endtask

  typedef struct {
    logic [6:0] addr;
    logic       exp_bit;
  } rd_vec_t;

  rd_vec_t rd_tab[10];

  // ---------------- test ----------------
  initial begin
    rd_tab[0] = '{7'd0,   1'b1};
    rd_tab[1] = '{7'd1,   1'b0};
    rd_tab[2] = '{7'd2,   1'b1};
    rd_tab[3] = '{7'd3,   1'b0};
    rd_tab[4] = '{7'd7,   1'b1};
    rd_tab[5] = '{7'd8,   1'b1};
    rd_tab[6] = '{7'd118, 1'b0};
    rd_tab[7] = '{7'd119, 1'b1};
    rd_tab[8] = '{7'd120, 1'b0};
    rd_tab[9] = '{7'd127, 1'b0};

    rst = 1'b1; frame_start = 1'b0; msg_addr = '0;
    host_if.wr_valid = 1'b0; host_if.wr_addr = '0; host_if.wr_data = '0;
    host_if.commit_valid = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    check("rst_msg_bit", 32'(msg_bit), 32'd0);
    check("rst_active", 32'(active_bank), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_repeat", 32'(repeat_cnt), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);

    // Boundary with nothing committed: repeat only.
    frame();
    check("first_repeat", 32'(repeat_cnt), 32'd1);
    check("first_no_swap", 32'(swap_pulse), 32'd0);
    for (int i = 0; i < 6; i++) rd($urandom_range(0, 127));

    // Full A5 message, commit, blocked writes while pending, then swap.
    for (int w = 0; w < 15; w++) wr(w, 8'hA5);
    commit();
    check("pending_set", 32'(pending), 32'd1);
    host_if.wr_valid = 1'b1; host_if.wr_addr = 4'd0; host_if.wr_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      check("blocked_ready", 32'(host_if.wr_ready), 32'd0);
      cycle();
    end
    host_if.wr_valid = 1'b0;
    frame();
    check("swap_pulse_hi", 32'(swap_pulse), 32'd1);
    check("swap_active", 32'(active_bank), 32'd1);
    check("swap_pending_clr", 32'(pending), 32'd0);
    check("swap_bit0", 32'(msg_bit), 32'd1);
    for (int i = 0; i < 10; i++) begin
      rd(int'(rd_tab[i].addr));
      check("tab_bit", 32'(msg_bit), 32'(rd_tab[i].exp_bit));
    end

    // Back-bank writes after the swap must not disturb the served message.
    wr(0, 8'h00);
    wr(1, 8'h3C);
    rd(0);
    check("front_stable", 32'(msg_bit), 32'd1);

    // Commit coincident with a boundary: no swap now, swap at the next one.
    host_if.commit_valid = 1'b1;
    frame();
    host_if.commit_valid = 1'b0;
    check("coinc_no_swap", 32'(swap_pulse), 32'd0);
    check("coinc_pending", 32'(pending), 32'd1);
    check("coinc_repeat", 32'(repeat_cnt), 32'd2);
    for (int i = 0; i < 4; i++) cycle();
    check("pending_hold", 32'(pending), 32'd1);
    frame();
    check("coinc_swap", 32'(swap_pulse), 32'd1);
    check("coinc_active", 32'(active_bank), 32'd0);
    rd(10); check("word1_bit10", 32'(msg_bit), 32'd1);
    rd(9);  check("word1_bit9", 32'(msg_bit), 32'd0);

    // Out-of-range write, last-word write, and tail addresses.
    wr(15, 8'h5A);
    check("wr_err_set", 32'(wr_err), 32'd1);
    wr(14, 8'hFF);
    commit();
    for (int i = 0; i < 3; i++) cycle();
    check("wr_err_sticky", 32'(wr_err), 32'd1);
    frame();
    for (int a = 104; a < 128; a++) begin
      rd(a);
      if (a >= 112) check("tail_bit", 32'(msg_bit), (a < 120) ? 32'd1 : 32'd0);
    end

    // Saturation of the repeat counter.
    while (m_repeat != 16'hFFFE) frame();
    check("repeat_fffe", 32'(repeat_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) frame();
    check("repeat_sat", 32'(repeat_cnt), 32'hFFFF);

    // Reset while a commit is pending discards it.
    wr(3, 8'hF0);
    commit();
    check("pre_rst_pending", 32'(pending), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst2_pending", 32'(pending), 32'd0);
    check("rst2_state", 32'(dbg_state), 32'(FILL));
    check("rst2_repeat", 32'(repeat_cnt), 32'd0);
    check("rst2_wr_err", 32'(wr_err), 32'd0);
    check("rst2_active", 32'(active_bank), 32'd0);
    rd(112); check("rst2_bank_clr", 32'(msg_bit), 32'd0);
    frame();
    check("rst2_no_swap", 32'(swap_pulse), 32'd0);
    check("rst2_repeat1", 32'(repeat_cnt), 32'd1);
    for (int i = 0; i < 8; i++) rd($urandom_range(0, 127));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
